// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop; 16x oversampling.
// Define RX_SYNC_EN to pass RxD through a 2-flop synchronizer before use.
module uart_receiver #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       RX_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_VALID
);

    localparam int DIV_300    = (CLK_HZ + 8 * 300)    / (16 * 300);
    localparam int DIV_1200   = (CLK_HZ + 8 * 1200)   / (16 * 1200);
    localparam int DIV_4800   = (CLK_HZ + 8 * 4800)   / (16 * 4800);
    localparam int DIV_9600   = (CLK_HZ + 8 * 9600)   / (16 * 9600);
    localparam int DIV_19200  = (CLK_HZ + 8 * 19200)  / (16 * 19200);
    localparam int DIV_38400  = (CLK_HZ + 8 * 38400)  / (16 * 38400);
    localparam int DIV_57600  = (CLK_HZ + 8 * 57600)  / (16 * 57600);
    localparam int DIV_115200 = (CLK_HZ + 8 * 115200) / (16 * 115200);
    localparam int CNT_W      = $clog2(DIV_300 + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         baud_q, baud_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               bit_q, bit_d;
    logic               seen_hi_q, seen_hi_d;
    logic               seen_lo_q, seen_lo_d;
    logic               noise_q, noise_d;
    logic               rxd_prev_q, rxd_prev_d;
    logic [7:0]         data_q, data_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   div_m1;
    logic               tick;
    logic               cell_noisy;
    logic               frame_ferr;
    logic               rxd_s;

`ifdef RX_SYNC_EN
    logic               rxd_meta_q, rxd_sync_q;
    assign rxd_s = rxd_sync_q;
`else
    assign rxd_s = RxD;
`endif

    always_comb begin
        case (baud_q)
            3'd0:    div_m1 = CNT_W'(DIV_300 - 1);
            3'd1:    div_m1 = CNT_W'(DIV_1200 - 1);
            3'd2:    div_m1 = CNT_W'(DIV_4800 - 1);
            3'd3:    div_m1 = CNT_W'(DIV_9600 - 1);
            3'd4:    div_m1 = CNT_W'(DIV_19200 - 1);
            3'd5:    div_m1 = CNT_W'(DIV_38400 - 1);
            3'd6:    div_m1 = CNT_W'(DIV_57600 - 1);
            default: div_m1 = CNT_W'(DIV_115200 - 1);
        endcase
    end

    assign tick = (cnt_q == div_m1);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_d      = bit_q;
        seen_hi_d  = seen_hi_q;
        seen_lo_d  = seen_lo_q;
        noise_d    = noise_q;
        rxd_prev_d = rxd_s;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;
        cell_noisy = bit_q ? seen_lo_q : seen_hi_q;
        frame_ferr = !bit_q || noise_q || cell_noisy;

        if (state_q == IDLE) begin
            baud_d = baud_select;
            if (baud_select != baud_q) begin
                cnt_d = '0;
            end
        end

        if (!RX_EN) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (rxd_prev_q && !rxd_s) begin
                state_d   = START;
                cnt_d     = '0;
                idx_d     = '0;
                bit_cnt_d = '0;
                parity_d  = 1'b0;
                seen_hi_d = 1'b0;
                seen_lo_d = 1'b0;
                noise_d   = 1'b0;
                perr_d    = 1'b0;
                ferr_d    = 1'b0;
            end
        end else if (tick) begin
            idx_d = idx_q + 4'd1;
            // Noise window: any disagreement with the mid-cell sample taints the frame.
            if (idx_q >= 4'd2 && idx_q <= 4'd13) begin
                seen_hi_d = seen_hi_q | rxd_s;
                seen_lo_d = seen_lo_q | !rxd_s;
            end
            if (idx_q == 4'd8) begin
                bit_d = rxd_s;
                case (state_q)
                    START:   if (rxd_s) state_d = IDLE;
                    DATA: begin
                        shift_d  = {rxd_s, shift_q[7:1]};
                        parity_d = parity_q ^ rxd_s;
                    end
                    PARITY:  parity_d = parity_q ^ rxd_s;
                    default: ;
                endcase
            end
            if (idx_q == 4'd15) begin
                noise_d   = noise_q | cell_noisy;
                seen_hi_d = 1'b0;
                seen_lo_d = 1'b0;
                case (state_q)
                    START:  state_d = DATA;
                    DATA: begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = PARITY;
                    end
                    PARITY: state_d = STOP;
                    STOP: begin
                        state_d = IDLE;
                        ferr_d  = frame_ferr;
                        perr_d  = parity_q;
                        if (!frame_ferr && !parity_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        // A start bit arriving right at the stop boundary must still be seen as an edge.
                        if (bit_q) rxd_prev_d = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit_q      <= 1'b0;
            seen_hi_q  <= 1'b0;
            seen_lo_q  <= 1'b0;
            noise_q    <= 1'b0;
            rxd_prev_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef RX_SYNC_EN
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_q      <= bit_d;
            seen_hi_q  <= seen_hi_d;
            seen_lo_q  <= seen_lo_d;
            noise_q    <= noise_d;
            rxd_prev_q <= rxd_prev_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
`ifdef RX_SYNC_EN
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
`endif
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;
    assign Rx_VALID  = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames, monitor pops expected results
// whenever the DUT pulses VALID or raises an error flag.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       RX_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_VALID;

    localparam int BIT_115200 = 16 * 27;
    localparam int BIT_9600   = 16 * 326;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic valid_last = 1'b0;
    logic flag_last  = 1'b0;

    uart_receiver #(.CLK_HZ(50000000)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .RX_EN       (RX_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR),
        .Rx_VALID    (Rx_VALID)
    );

    always #10 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        RxD = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; split>0 flips D0 after that many clocks to inject noise.
    task automatic apply_stimulus(input logic [7:0] d, input logic par, input logic stp,
                                  input int bit_clks, input int split, input logic chk_clear);
        drive_bit(1'b0, bit_clks);
        if (chk_clear) begin
            check_output("perr_cleared_at_start", {7'd0, Rx_PERROR}, 8'd0);
            check_output("ferr_cleared_at_start", {7'd0, Rx_FERROR}, 8'd0);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 0 && split > 0) begin
                drive_bit(d[0], split);
                drive_bit(~d[0], bit_clks - split);
            end else begin
                drive_bit(d[i], bit_clks);
            end
        end
        drive_bit(par, bit_clks);
        drive_bit(stp, bit_clks);
        RxD = 1'b1;
    endtask

    // Monitor: every VALID pulse or rising error flag is one frame result.
    always @(negedge clk) begin
        if (reset) begin
            valid_last = 1'b0;
            flag_last  = 1'b0;
        end else begin
            if (valid_last) check_output("valid_one_cycle", {7'd0, Rx_VALID}, 8'd0);
            if (Rx_VALID || ((Rx_PERROR || Rx_FERROR) && !flag_last)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_event: got valid=%0b perr=%0b ferr=%0b data=%0h expected none",
                             Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("rx_data",  Rx_DATA, e.data);
                    check_output("rx_perr",  {7'd0, Rx_PERROR}, {7'd0, e.perr});
                    check_output("rx_ferr",  {7'd0, Rx_FERROR}, {7'd0, e.ferr});
                    check_output("rx_valid", {7'd0, Rx_VALID},  {7'd0, e.valid});
                end
            end
            valid_last = Rx_VALID;
            flag_last  = Rx_PERROR || Rx_FERROR;
        end
    end

    initial begin
        #2500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        RxD         = 1'b1;
        RX_EN       = 1'b1;
        baud_select = 3'd7;
        repeat (20) @(negedge clk);
        check_output("reset_data",  Rx_DATA, 8'h00);
        check_output("reset_valid", {7'd0, Rx_VALID},  8'd0);
        check_output("reset_perr",  {7'd0, Rx_PERROR}, 8'd0);
        check_output("reset_ferr",  {7'd0, Rx_FERROR}, 8'd0);
        reset = 1'b0;
        drive_bit(1'b1, 60);

        exp_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0, valid: 1'b1});
        apply_stimulus(8'hA5, 1'b0, 1'b1, BIT_115200, 0, 1'b0);
        drive_bit(1'b1, 40);

        // D0 high 248 clocks (past mid-cell sample) then low: noisy cell.
        exp_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b1, valid: 1'b0});
        apply_stimulus(8'h85, 1'b1, 1'b1, BIT_115200, 248, 1'b0);
        drive_bit(1'b1, 40);

        exp_q.push_back('{data: 8'hA5, perr: 1'b1, ferr: 1'b0, valid: 1'b0});
        apply_stimulus(8'h85, 1'b0, 1'b1, BIT_115200, 0, 1'b0);
        drive_bit(1'b1, 40);

        exp_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b1, valid: 1'b0});
        apply_stimulus(8'h5A, 1'b0, 1'b0, BIT_115200, 0, 1'b1);
        drive_bit(1'b1, 40);

        drive_bit(1'b0, 86);
        drive_bit(1'b1, 600);
        check_output("glitch_perr", {7'd0, Rx_PERROR}, 8'd0);
        check_output("glitch_ferr", {7'd0, Rx_FERROR}, 8'd0);
        check_output("glitch_data", Rx_DATA, 8'hA5);

        // Abort in the middle of D3 of 0x3C.
        drive_bit(1'b0, BIT_115200);
        drive_bit(1'b0, BIT_115200);
        drive_bit(1'b0, BIT_115200);
        drive_bit(1'b1, BIT_115200);
        drive_bit(1'b1, BIT_115200 / 2);
        RX_EN = 1'b0;
        repeat (8) @(negedge clk);
        RX_EN = 1'b1;
        drive_bit(1'b1, 3500);
        check_output("abort_perr", {7'd0, Rx_PERROR}, 8'd0);
        check_output("abort_ferr", {7'd0, Rx_FERROR}, 8'd0);
        check_output("abort_data", Rx_DATA, 8'hA5);

        baud_select = 3'd3;
        drive_bit(1'b1, 20);
        exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0, valid: 1'b1});
        apply_stimulus(8'h3C, 1'b0, 1'b1, BIT_9600, 0, 1'b0);
        drive_bit(1'b1, 40);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check_output("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        check_output("final_data", Rx_DATA, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
